// File: rtl/mem_arb_pkg.sv
// Shared definitions for the Mem-stage data-port arbiter.
//   LANES_DEFAULT : number of 32-bit words moved by one vector access
//   WORD_BYTES    : byte stride between consecutive vector lanes
//   arbState_t    : arbiter states (idle / vector beats / vector completion)
package mem_arb_pkg;

  localparam int LANES_DEFAULT = 4;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VBEAT = 2'd1,
    VLAST = 2'd2
  } arbState_t;

endpackage

// File: rtl/vec_lane_buffer.sv
// Lane storage for assembling vector load data one word at a time.
//   clk, rst_n : clock, asynchronous active-low reset (clears every lane)
//   wrEn       : write wrData into lane wrLane at the next rising edge
//   wrLane     : lane index being written
//   wrData     : word to store
//   rdVec      : all lanes, lane 0 in the low word
module vec_lane_buffer
  import mem_arb_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int DW    = 32,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrEn,
  input  logic [LW-1:0]       wrLane,
  input  logic [DW-1:0]       wrData,
  output logic [LANES*DW-1:0] rdVec
);

  logic [DW-1:0] lanes [LANES];

  // One lane is updated per cycle as read beats return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) lanes[i] <= '0;
    end else if (wrEn) begin
      lanes[wrLane] <= wrData;
    end
  end

  // The lane being written is forwarded so the final beat's word is already
  // visible in the cycle it arrives, which is the vec_done cycle.
  always_comb begin
    rdVec = '0;
    for (int i = 0; i < LANES; i++) begin
      rdVec[i*DW +: DW] = (wrEn && (wrLane == LW'(i))) ? wrData : lanes[i];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between scalar LDR/STR and
// multi-beat vector LDRV/STRV accesses. Scalar wins in IDLE; a granted
// vector access runs to completion without preemption.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   scal_req/we/addr/wdata      : scalar request from the Mem stage
//   scal_gnt/rvalid/rdata       : scalar accept, load data one cycle later
//   vec_req/we/addr/wdata       : vector request, base address, lane data
//   vec_gnt/done/rdata          : vector accept pulse, completion pulse, lanes
//   mem_en/we/addr/wdata, mem_rdata : synchronous data memory port
//   stall_req                   : asks the hazard unit to freeze the pipe
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scal_req,
  input  logic                scal_we,
  input  logic [AW-1:0]       scal_addr,
  input  logic [DW-1:0]       scal_wdata,
  output logic                scal_gnt,
  output logic                scal_rvalid,
  output logic [DW-1:0]       scal_rdata,
  input  logic                vec_req,
  input  logic                vec_we,
  input  logic [AW-1:0]       vec_addr,
  input  logic [LANES*DW-1:0] vec_wdata,
  output logic                vec_gnt,
  output logic                vec_done,
  output logic [LANES*DW-1:0] vec_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                stall_req
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  arbState_t           state, stateNext;
  logic [LW-1:0]       beat;
  logic [AW-1:0]       vecBase;
  logic                vecWeQ;
  logic [LANES*DW-1:0] vecWdataQ;
  logic                rdPend;
  logic [LW-1:0]       rdLane;
  logic                scalRvalidQ;
  logic                scalGo;
  logic                vecGo;
  logic                lastBeat;
  logic [AW-1:0]       beatAddr;
  logic [AW-1:0]       addrRaw;

  assign scalGo   = (state == IDLE) && scal_req;
  assign vecGo    = (state == IDLE) && !scal_req && vec_req;
  assign lastBeat = (beat == LW'(LANES - 1));
  // Wraps modulo 2^AW, so a vector may straddle the top of the address space.
  assign beatAddr = vecBase + (AW'(beat) * AW'(WORD_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (vec_req && !scal_req) stateNext = VBEAT;
      VBEAT:   if (lastBeat) stateNext = VLAST;
      VLAST:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Vector request is captured at grant so the requester may drop it; read
  // beats are remembered for one cycle to steer the returning word to its lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat        <= '0;
      vecBase     <= '0;
      vecWeQ      <= 1'b0;
      vecWdataQ   <= '0;
      rdPend      <= 1'b0;
      rdLane      <= '0;
      scalRvalidQ <= 1'b0;
    end else begin
      scalRvalidQ <= scalGo && !scal_we;
      rdPend      <= (state == VBEAT) && !vecWeQ;
      rdLane      <= beat;
      if (vecGo) begin
        beat      <= '0;
        vecBase   <= vec_addr;
        vecWeQ    <= vec_we;
        vecWdataQ <= vec_wdata;
      end else if (state == VBEAT) begin
        beat <= beat + LW'(1);
      end
    end
  end

  // Outputs are gated by rst_n so an asserted reset silences the port at once,
  // even while scal_req is still high.
  always_comb begin
    scal_gnt  = 1'b0;
    vec_gnt   = 1'b0;
    vec_done  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    addrRaw   = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (scal_req) begin
            scal_gnt  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = scal_we;
            addrRaw   = scal_addr;
            mem_wdata = scal_wdata;
          end else if (vec_req) begin
            vec_gnt = 1'b1;
          end
        end
        VBEAT: begin
          mem_en    = 1'b1;
          mem_we    = vecWeQ;
          addrRaw   = beatAddr;
          mem_wdata = vecWdataQ[int'(beat)*DW +: DW];
        end
        VLAST:   vec_done = 1'b1;
        default: ;
      endcase
    end
    mem_addr  = addrRaw & ~AW'(WORD_BYTES - 1);
    stall_req = rst_n & ((state != IDLE) | (scal_req & !scal_gnt) | (vec_req & !vec_gnt));
  end

  assign scal_rvalid = scalRvalidQ;
  assign scal_rdata  = mem_rdata;

  vec_lane_buffer #(.LANES(LANES), .DW(DW), .LW(LW)) laneBuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (rdPend),
    .wrLane (rdLane),
    .wrData (mem_rdata),
    .rdVec  (vec_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model keyed on
// the cycle a vector was granted, a synchronous memory, directed scenarios
// with literal expectations, and a randomized phase.
module tb_mem_port_arbiter;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int VW    = LANES * DW;
  localparam int LOGN  = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scal_req, scal_we;
  logic [AW-1:0] scal_addr;
  logic [DW-1:0] scal_wdata;
  logic          scal_gnt, scal_rvalid;
  logic [DW-1:0] scal_rdata;
  logic          vec_req, vec_we;
  logic [AW-1:0] vec_addr;
  logic [VW-1:0] vec_wdata;
  logic          vec_gnt, vec_done;
  logic [VW-1:0] vec_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] memRdata = '0;
  logic          stall_req;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .scal_req(scal_req), .scal_we(scal_we), .scal_addr(scal_addr), .scal_wdata(scal_wdata),
    .scal_gnt(scal_gnt), .scal_rvalid(scal_rvalid), .scal_rdata(scal_rdata),
    .vec_req(vec_req), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .vec_gnt(vec_gnt), .vec_done(vec_done), .vec_rdata(vec_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(memRdata), .stall_req(stall_req)
  );

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory; unwritten words return an address-derived pattern.
  logic [DW-1:0] memArr [logic [AW-1:0]];

  function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) memArr[mem_addr] = mem_wdata;
      else        memRdata <= memRead(mem_addr);
    end
  end

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle log of DUT outputs, used by the directed literal checks.
  logic          logSGnt [LOGN];
  logic          logVGnt [LOGN];
  logic          logDone [LOGN];
  logic          logEn   [LOGN];
  logic          logWe   [LOGN];
  logic          logStall[LOGN];
  logic          logSRv  [LOGN];
  logic [AW-1:0] logAddr [LOGN];
  logic [DW-1:0] logWd   [LOGN];
  logic [DW-1:0] logSRd  [LOGN];
  logic [VW-1:0] logVRd  [LOGN];

  // Model state: a vector is described by its grant cycle, so the beat number
  // is simply (cycle - grant cycle - 1).
  bit            mVecActive = 0;
  int            mVecT0 = 0;
  logic [AW-1:0] mBase = '0;
  bit            mWe = 0;
  logic [VW-1:0] mWdata = '0;
  logic [VW-1:0] mLanes = '0;
  bit            mLanePend = 0;
  int            mLaneIdx = 0;
  logic [DW-1:0] mLaneVal = '0;
  bit            mRvPend = 0;
  logic [DW-1:0] mRvVal = '0;

  logic          eSG, eVG, eVD, eEn, eWe, eStall, eSRv, wasActive;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eWd, eSRd;
  int            phase, k;

  // Compare process: mid-cycle, inputs and combinational outputs are stable.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      logSGnt[cyc] = scal_gnt;  logVGnt[cyc] = vec_gnt;   logDone[cyc] = vec_done;
      logEn[cyc]   = mem_en;    logWe[cyc]   = mem_we;    logStall[cyc] = stall_req;
      logSRv[cyc]  = scal_rvalid; logAddr[cyc] = mem_addr; logWd[cyc] = mem_wdata;
      logSRd[cyc]  = scal_rdata;  logVRd[cyc] = vec_rdata;
    end
    if (!rst_n) begin
      mVecActive = 0; mLanePend = 0; mRvPend = 0; mLanes = '0;
      checkOutput("rstScalGnt", scal_gnt, 0);
      checkOutput("rstVecGnt", vec_gnt, 0);
      checkOutput("rstVecDone", vec_done, 0);
      checkOutput("rstRvalid", scal_rvalid, 0);
      checkOutput("rstMemEn", mem_en, 0);
      checkOutput("rstMemWe", mem_we, 0);
      checkOutput("rstStall", stall_req, 0);
      checkOutput("rstVecRdata", vec_rdata, 0);
    end else begin
      if (mLanePend) mLanes[mLaneIdx*DW +: DW] = mLaneVal;
      mLanePend = 0;
      eSRv = mRvPend; eSRd = mRvVal; mRvPend = 0;
      eSG = 0; eVG = 0; eVD = 0; eEn = 0; eWe = 0; eAddr = '0; eWd = '0;
      wasActive = mVecActive;
      if (!mVecActive) begin
        if (scal_req) begin
          eSG = 1; eEn = 1; eWe = scal_we;
          eAddr = scal_addr & ~32'h3; eWd = scal_wdata;
          if (!scal_we) begin mRvPend = 1; mRvVal = memRead(eAddr); end
        end else if (vec_req) begin
          eVG = 1; mVecActive = 1; mVecT0 = cyc;
          mBase = vec_addr; mWe = vec_we; mWdata = vec_wdata;
        end
      end else begin
        phase = cyc - mVecT0;
        if (phase <= LANES) begin
          k = phase - 1;
          eEn = 1; eWe = mWe;
          eAddr = (mBase + 32'(4 * k)) & ~32'h3;
          eWd = mWdata[k*DW +: DW];
          if (!mWe) begin mLanePend = 1; mLaneIdx = k; mLaneVal = memRead(eAddr); end
        end else begin
          eVD = 1; mVecActive = 0;
        end
      end
      eStall = wasActive | (scal_req & !eSG) | (vec_req & !eVG);
      checkOutput("scalGnt", scal_gnt, eSG);
      checkOutput("vecGnt", vec_gnt, eVG);
      checkOutput("vecDone", vec_done, eVD);
      checkOutput("scalRvalid", scal_rvalid, eSRv);
      checkOutput("memEn", mem_en, eEn);
      checkOutput("memWe", mem_we, eWe);
      checkOutput("stallReq", stall_req, eStall);
      if (eEn) checkOutput("memAddr", mem_addr, eAddr);
      if (eEn && eWe) checkOutput("memWdata", mem_wdata, eWd);
      if (eSRv) checkOutput("scalRdata", scal_rdata, eSRd);
      if (!wasActive || eVD) checkOutput("vecRdata", vec_rdata, mLanes);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sReq, input bit sWe, input logic [AW-1:0] sAddr,
                               input logic [DW-1:0] sWd, input bit vReq, input bit vWe,
                               input logic [AW-1:0] vAddr, input logic [VW-1:0] vWd);
    scal_req = sReq; scal_we = sWe; scal_addr = sAddr; scal_wdata = sWd;
    vec_req = vReq; vec_we = vWe; vec_addr = vAddr; vec_wdata = vWd;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  int c, c2;
  logic [AW-1:0] litAddr [4];
  logic [AW-1:0] ra;

  initial begin
    idleInputs();
    rst_n = 1'b0;
    memArr[32'h10]  = 32'hDEAD_BEEF;
    memArr[32'h100] = 32'h1111_1111;
    memArr[32'h104] = 32'h2222_2222;
    memArr[32'h108] = 32'h3333_3333;
    memArr[32'h10C] = 32'h4444_4444;
    step();
    applyStimulus(1, 0, 32'h10, '0, 1, 0, 32'h100, '0);
    #1;
    checkOutput("litRstGnt", scal_gnt, 0);
    checkOutput("litRstStall", stall_req, 0);
    step();
    idleInputs();
    rst_n = 1'b1;
    step();

    // Scalar read in IDLE.
    applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
    c = cyc;
    step(); idleInputs(); step(); step();
    checkOutput("litScalGnt", logSGnt[c], 1);
    checkOutput("litScalAddr", logAddr[c], 32'h10);
    checkOutput("litScalRvalid", logSRv[c+1], 1);
    checkOutput("litScalRdata", logSRd[c+1], 32'hDEAD_BEEF);

    // Vector read at base 0x100.
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h100, '0);
    c = cyc;
    step(); idleInputs(); repeat (6) step();
    checkOutput("litVecGnt", logVGnt[c], 1);
    checkOutput("litVecGntNoMem", logEn[c], 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("litVecRdAddr", logAddr[c+1+i], 32'h100 + 32'(4*i));
      checkOutput("litVecRdEn", logEn[c+1+i], 1);
    end
    checkOutput("litVecDoneEarly", logDone[c+4], 0);
    checkOutput("litVecDone", logDone[c+5], 1);
    checkOutput("litVecLanes", logVRd[c+5], 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    checkOutput("litVecHold", logVRd[c+6], 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    for (int i = 1; i <= 5; i++) checkOutput("litVecStall", logStall[c+i], 1);
    checkOutput("litVecStallEnd", logStall[c+6], 0);

    // Simultaneous requests: scalar first, vector one cycle later.
    applyStimulus(1, 0, 32'h20, '0, 1, 0, 32'h200, '0);
    c = cyc;
    step();
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h200, '0);
    step(); idleInputs(); repeat (6) step();
    checkOutput("litBothScal", logSGnt[c], 1);
    checkOutput("litBothVecWait", logVGnt[c], 0);
    checkOutput("litBothStall", logStall[c], 1);
    checkOutput("litBothVecNext", logVGnt[c+1], 1);

    // Vector write wrapping past the top of the address space.
    litAddr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    applyStimulus(0, 0, '0, '0, 1, 1, 32'hFFFF_FFF8, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    c = cyc;
    step(); idleInputs(); repeat (6) step();
    for (int i = 0; i < 4; i++) begin
      checkOutput("litVecWrAddr", logAddr[c+1+i], litAddr[i]);
      checkOutput("litVecWrWe", logWe[c+1+i], 1);
    end
    checkOutput("litVecWrData2", logWd[c+3], 32'hCCCC_CCCC);
    checkOutput("litVecWrDone", logDone[c+5], 1);
    for (int i = 1; i <= 6; i++) checkOutput("litVecWrNoRv", logSRv[c+i], 0);
    checkOutput("litVecWrMem0", memArr[32'h0], 32'hCCCC_CCCC);

    // Scalar raised mid-vector waits until the arbiter returns to IDLE.
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h300, '0);
    c = cyc;
    step(); idleInputs(); step();
    applyStimulus(1, 0, 32'h40, '0, 0, 0, '0, '0);
    repeat (4) step();
    step(); idleInputs(); step();
    for (int i = 2; i <= 5; i++) begin
      checkOutput("litWaitGnt", logSGnt[c+i], 0);
      checkOutput("litWaitStall", logStall[c+i], 1);
    end
    checkOutput("litWaitGranted", logSGnt[c+6], 1);
    checkOutput("litWaitStallOff", logStall[c+6], 0);

    // Reset in the middle of a vector read.
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h400, '0);
    c = cyc;
    step(); idleInputs(); step();
    rst_n = 1'b0;
    #1;
    checkOutput("litMidRstEn", mem_en, 0);
    checkOutput("litMidRstStall", stall_req, 0);
    checkOutput("litMidRstLanes", vec_rdata, 0);
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    for (int i = 2; i <= 8; i++) checkOutput("litMidRstNoDone", logDone[c+i], 0);
    applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
    c2 = cyc;
    step(); idleInputs(); step(); step();
    checkOutput("litPostRstGnt", logSGnt[c2], 1);
    checkOutput("litPostRstData", logSRd[c2+1], 32'hDEAD_BEEF);

    // Randomized traffic with occasional single-cycle resets.
    for (int n = 0; n < 600; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : (32'($urandom) & 32'h0000_0FFF);
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, ra, $urandom,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                    32'($urandom) & 32'h0000_0FFF,
                    {$urandom, $urandom, $urandom, $urandom});
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    idleInputs();
    rst_n = 1'b1;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
